hist_mass_scanner: RTL and testbench
====================================

Name: hist_mass_scanner

Overview:
Sequential consumer of the 256:1 histogram bin multiplexer. On `start` it drives the bin select from 0 upward and reads one bin count per cycle from the mux output. It accumulates cumulative pixel mass and reports the first intensity level at which the cumulative mass reaches a programmed target. This yields a threshold or percentile intensity plus the mass count at that level, for the output stage.

Parameters:
WIDTH, 8, width of one histogram bin count; equals the mux data width.
SUM_W, 16, width of the cumulative mass accumulator, target and mass output; must be >= WIDTH.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
target  input  SUM_W  cumulative mass threshold; latched when start is accepted.
bin_count  input  WIDTH  count of the currently selected bin (mux y); combinational from sel in the same cycle.
sel  output  8  bin select driven to the mux s input.
busy  output  1  high in SCAN and DONE.
done  output  1  high for exactly one cycle when the result is valid.
found  output  1  1 = target reached, 0 = histogram exhausted first; valid while done=1 and held until the next start.
level  output  8  intensity level (bin index) of the result; held until the next start.
mass  output  SUM_W  cumulative mass through `level` inclusive; held until the next start.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state=IDLE.
  - sel, level, mass, internal acc and latched target all = 0.
  - busy=0, done=0, found=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start=1 → latch target, acc<=0, sel<=0, found<=0, go to SCAN.
  - start=0 → hold all outputs.
- SCAN, each cycle:
  - sum = acc + bin_count, computed at SUM_W+1 bits; saturates to 2^SUM_W-1 if the carry is set.
  - If sum >= target: found<=1, level<=sel, mass<=sum, go to DONE.
  - Else if sel==255: found<=0, level<=255, mass<=sum, go to DONE. sel does not wrap.
  - Else: acc<=sum, sel<=sel+1.
- DONE: done=1 (Moore output of this state); next cycle go to IDLE. sel holds its last value.
- busy = (state != IDLE). done = (state == DONE).
- Latency, with the start cycle as cycle 0:
  - Bin k is evaluated in cycle k+1.
  - A hit at bin k gives done=1 in cycle k+2.
  - A full miss gives done=1 in cycle 257.
- target=0: hit at bin 0 in cycle 1; level=0, mass=bin 0 count.
- start asserted while busy is ignored. target changes after acceptance have no effect.
- start in the same cycle as reset: reset wins; no scan begins.
- Reset during SCAN or DONE: abort immediately to reset values; done is not asserted.
- start in the cycle after DONE (state IDLE) is accepted; back-to-back scans incur no extra idle cycle.
- Saturation: once acc reaches 2^SUM_W-1 it stays there. With target <= 2^SUM_W-1 the comparison therefore hits at the saturating bin.

Decomposition:
- Package hist_pkg holds:
  - NUM_BINS=256
  - SEL_W=8
  - LAST_BIN=8'd255
  - typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t
- No sub-module; the saturating adder and compare stay inline.
- The top level connects sel→mux s and mux y→bin_count.

Test Plan:
- All bins = 1, target=10, start in cycle 0 → done in cycle 11, found=1, level=9, mass=10, sel=9.
- All bins = 1, target=300 → done in cycle 257, found=0, level=255, mass=256.
- Bins 0..99 = 0, bin 100 = 7, rest = 0, target=0 → done in cycle 2, found=1, level=0, mass=0. Then target=5 → level=100, mass=7, done in cycle 102.
- SUM_W=12, all bins = 255, target=4095 → acc saturates at bin 16 (17*255=4335 clipped); found=1, level=16, mass=4095.
- Reset asserted in cycle 50 of a scan → in the next cycle busy=0, sel=0, level=0, mass=0, found=0; done never asserted. A subsequent start runs a normal scan.
- start held high across a whole scan with target=3 and all bins = 1 → first result level=2, mass=3. Re-accepted in the cycle after done; the second scan produces an identical result with done 4 cycles after acceptance. No start is accepted mid-scan.

Source files
------------

// File: rtl/hist_mass_scanner_pkg.sv
// hist_pkg: shared constants and types for the histogram mass scanner.
//   NUM_BINS     number of histogram bins behind the 256:1 mux
//   SEL_W        width of the mux bin select
//   LAST_BIN     highest bin index; the scan stops here without wrapping
//   scan_state_t scanner FSM states
package hist_pkg;
  localparam int           NUM_BINS = 256;
  localparam int           SEL_W    = 8;
  localparam logic [7:0]   LAST_BIN = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;
endpackage

// File: rtl/hist_mass_scanner_if.sv
// hist_scan_if: request/result bus between a client and the mass scanner.
//   start   client -> scanner  one-cycle scan request
//   target  client -> scanner  cumulative mass threshold
//   busy    scanner -> client  scan in progress (SCAN or DONE)
//   done    scanner -> client  one-cycle result strobe
//   found   scanner -> client  1 = target reached, 0 = histogram exhausted
//   level   scanner -> client  bin index of the result
//   mass    scanner -> client  cumulative mass through level
// Modports: master = client side, slave = scanner side.
interface hist_scan_if
  import hist_pkg::*;
#(
  parameter int SUM_W = 16
);
  logic             start;
  logic [SUM_W-1:0] target;
  logic             busy;
  logic             done;
  logic             found;
  logic [SEL_W-1:0] level;
  logic [SUM_W-1:0] mass;

  modport master (
    output start, target,
    input  busy, done, found, level, mass
  );

  modport slave (
    input  start, target,
    output busy, done, found, level, mass
  );
endinterface

// File: rtl/hist_mass_scanner.sv
// hist_mass_scanner: walks the histogram mux from bin 0 upward, one bin per
// cycle, accumulating pixel mass, and reports the first bin at which the
// cumulative mass reaches the latched target (threshold / percentile search).
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   bus        hist_scan_if.slave: start/target in, busy/done/found/level/mass out
//   sel        bin select to the mux s input
//   bin_count  mux y output; combinational from sel in the same cycle
// WIDTH must not exceed SUM_W.
module hist_mass_scanner
  import hist_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SUM_W = 16
)(
  input  logic             clk,
  input  logic             reset,
  hist_scan_if.slave       bus,
  output logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] bin_count
);
  localparam logic [SUM_W-1:0] SAT_MAX = {SUM_W{1'b1}};

  scan_state_t      state_q,  state_d;
  logic [SEL_W-1:0] sel_q,    sel_d;
  logic [SEL_W-1:0] level_q,  level_d;
  logic [SUM_W-1:0] acc_q,    acc_d;
  logic [SUM_W-1:0] target_q, target_d;
  logic [SUM_W-1:0] mass_q,   mass_d;
  logic             found_q,  found_d;

  logic [SUM_W:0]   sum_wide;
  logic [SUM_W-1:0] sum_sat;

  // One extra bit catches the carry; on carry the sum pins at all-ones so
  // any representable target is still reached at the overflowing bin.
  always_comb begin
    sum_wide = {1'b0, acc_q} + {{(SUM_W + 1 - WIDTH){1'b0}}, bin_count};
    sum_sat  = sum_wide[SUM_W] ? SAT_MAX : sum_wide[SUM_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    level_d  = level_q;
    acc_d    = acc_q;
    target_d = target_q;
    mass_d   = mass_q;
    found_d  = found_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          target_d = bus.target;
          acc_d    = '0;
          sel_d    = '0;
          found_d  = 1'b0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (sum_sat >= target_q) begin
          found_d = 1'b1;
          level_d = sel_q;
          mass_d  = sum_sat;
          state_d = DONE;
        end else if (sel_q == LAST_BIN) begin
          // Histogram exhausted; sel stays at the last bin.
          found_d = 1'b0;
          level_d = LAST_BIN;
          mass_d  = sum_sat;
          state_d = DONE;
        end else begin
          acc_d = sum_sat;
          sel_d = sel_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      level_q  <= '0;
      acc_q    <= '0;
      target_q <= '0;
      mass_q   <= '0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      level_q  <= level_d;
      acc_q    <= acc_d;
      target_q <= target_d;
      mass_q   <= mass_d;
      found_q  <= found_d;
    end
  end

  assign sel       = sel_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.found = found_q;
  assign bus.level = level_q;
  assign bus.mass  = mass_q;
endmodule

// File: tb/tb_hist_mass_scanner.sv
// Testbench for hist_mass_scanner: a behavioural model (cumulative walk over
// the bench histogram) is checked against the 16-bit DUT every cycle, and
// directed scenarios pin results to hand-computed literals. A second DUT
// with SUM_W=12 covers accumulator saturation.
module tb_hist_mass_scanner;
  import hist_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] hist [NUM_BINS];

  hist_scan_if #(.SUM_W(16)) bus16 ();
  hist_scan_if #(.SUM_W(12)) bus12 ();
  logic [7:0] sel16, sel12;
  logic [7:0] bin16, bin12;
  assign bin16 = hist[sel16];
  assign bin12 = hist[sel12];

  hist_mass_scanner #(.WIDTH(8), .SUM_W(16)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16.slave), .sel(sel16), .bin_count(bin16)
  );
  hist_mass_scanner #(.WIDTH(8), .SUM_W(12)) dut12 (
    .clk(clk), .reset(reset), .bus(bus12.slave), .sel(sel12), .bin_count(bin12)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < NUM_BINS; i++) hist[i] = v[7:0];
  endtask

  // Reference: cumulative walk over the histogram, clipped at 2^16-1.
  function automatic void model(input int tgt, output int dcyc, output bit f,
                                output int lvl, output int m);
    int cum = 0;
    for (int k = 0; k < NUM_BINS; k++) begin
      cum += int'(hist[k]);
      if (cum > 65535) cum = 65535;
      if (cum >= tgt) begin
        f = 1'b1; lvl = k; m = cum; dcyc = k + 2;
        return;
      end
    end
    f = 1'b0; lvl = 255; m = cum; dcyc = 257;
  endfunction

  // Model state for dut16.
  bit m_active = 1'b0;
  int m_cyc = 0, m_dcyc = 0;
  bit r_found = 1'b0;
  int r_level = 0, r_mass = 0;
  bit e_found = 1'b0;
  int e_level = 0, e_mass = 0, e_sel_idle = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0; m_cyc = 0;
      e_found = 1'b0; e_level = 0; e_mass = 0; e_sel_idle = 0;
    end else if (m_active) begin
      if (m_cyc == m_dcyc) begin
        m_active = 1'b0;
      end else begin
        m_cyc++;
        if (m_cyc == m_dcyc) begin
          e_found = r_found; e_level = r_level; e_mass = r_mass; e_sel_idle = r_level;
        end
      end
    end else if (bus16.start === 1'b1) begin
      model(int'(bus16.target), m_dcyc, r_found, r_level, r_mass);
      m_active = 1'b1; m_cyc = 1; e_found = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int exp_sel;
      exp_sel = (m_active && m_cyc < m_dcyc) ? m_cyc - 1 : e_sel_idle;
      chk("busy",  32'(bus16.busy),  32'(m_active));
      chk("done",  32'(bus16.done),  32'(m_active && m_cyc == m_dcyc));
      chk("sel",   32'(sel16),       32'(exp_sel));
      chk("found", 32'(bus16.found), 32'(e_found));
      chk("level", 32'(bus16.level), 32'(e_level));
      chk("mass",  32'(bus16.mass),  32'(e_mass));
    end
  end

  // Called at a negedge with dut16 idle; returns at the negedge after done.
  task automatic run16(input string nm, input int tgt, input int ecyc, input int ef,
                       input int el, input int em);
    int cyc;
    bus16.target = tgt[15:0];
    bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    bus16.target = 16'hBEEF;  // must not affect the running scan
    cyc = 1;
    while (bus16.done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " done_cycle"}, 32'(cyc), 32'(ecyc));
    chk({nm, " found"}, 32'(bus16.found), 32'(ef));
    chk({nm, " level"}, 32'(bus16.level), 32'(el));
    chk({nm, " mass"},  32'(bus16.mass),  32'(em));
    $display("[TB] %s: target=%0d cycle=%0d found=%0d level=%0d mass=%0d",
             nm, tgt, cyc, bus16.found, bus16.level, bus16.mass);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    fill(1);
    bus16.start = 1'b1;  // start during reset must be ignored
    bus16.target = 16'd0;
    bus12.start = 1'b1;
    bus12.target = 12'd0;
    repeat (3) @(negedge clk);
    bus16.start = 1'b0;
    bus12.start = 1'b0;
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset busy",  32'(bus16.busy), 32'd0);
    chk("reset sel",   32'(sel16), 32'd0);
    chk("reset mass",  32'(bus16.mass), 32'd0);
    chk("reset12 busy", 32'(bus12.busy), 32'd0);
    chk("reset12 done", 32'(bus12.done), 32'd0);

    // All ones, hit at bin 9.
    run16("ones_t10", 10, 11, 1, 9, 10);
    chk("ones_t10 sel held", 32'(sel16), 32'd9);

    // All ones, target beyond total mass: full miss.
    run16("ones_t300", 300, 257, 0, 255, 256);
    chk("ones_t300 sel held", 32'(sel16), 32'd255);

    // Single populated bin at 100.
    fill(0);
    hist[100] = 8'd7;
    run16("zero_t0", 0, 2, 1, 0, 0);
    run16("bin100_t5", 5, 102, 1, 100, 7);

    // Reset in the middle of a scan.
    fill(1);
    bus16.target = 16'd1000;
    bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    repeat (49) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy",  32'(bus16.busy),  32'd0);
    chk("abort sel",   32'(sel16),       32'd0);
    chk("abort level", 32'(bus16.level), 32'd0);
    chk("abort mass",  32'(bus16.mass),  32'd0);
    chk("abort found", 32'(bus16.found), 32'd0);
    $display("[TB] abort: busy=%0d sel=%0d level=%0d mass=%0d", bus16.busy, sel16,
             bus16.level, bus16.mass);
    run16("after_abort", 10, 11, 1, 9, 10);

    // start held high: back-to-back scans with no idle gap beyond IDLE.
    bus16.target = 16'd3;
    bus16.start = 1'b1;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      cyc = 1;
      while (bus16.done !== 1'b1 && cyc < 400) begin
        @(negedge clk);
        cyc++;
      end
      chk("held done_cycle", 32'(cyc), 32'd4);
      chk("held level", 32'(bus16.level), 32'd2);
      chk("held mass",  32'(bus16.mass),  32'd3);
      $display("[TB] held scan %0d: cycle=%0d level=%0d mass=%0d", s, cyc,
               bus16.level, bus16.mass);
      if (s == 0) begin
        @(negedge clk);
        chk("held idle gap busy", 32'(bus16.busy), 32'd0);
      end
    end
    bus16.start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Saturation on the 12-bit accumulator: 17*255 clips to 4095 at bin 16.
    fill(255);
    bus12.target = 12'd4095;
    bus12.start = 1'b1;
    @(negedge clk);
    bus12.start = 1'b0;
    cyc = 1;
    while (bus12.done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("sat12 done_cycle", 32'(cyc), 32'd18);
    chk("sat12 found", 32'(bus12.found), 32'd1);
    chk("sat12 level", 32'(bus12.level), 32'd16);
    chk("sat12 mass",  32'(bus12.mass),  32'd4095);
    $display("[TB] sat12: cycle=%0d found=%0d level=%0d mass=%0d", cyc, bus12.found,
             bus12.level, bus12.mass);
    @(negedge clk);
    chk("sat12 idle", 32'(bus12.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
